// File: rtl/reg_pkg.sv
// reg_pkg: types and defaults shared by the register access controller, its
// bus interface and its busy scoreboard.
//   DATA_W_DEFAULT : default operand / register data width
//   NUM_REGS       : number of architectural registers (one busy bit each)
//   RegNum         : register number type
//   state_e        : controller FSM states
package reg_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned NUM_REGS       = 32;

   typedef logic [$clog2(NUM_REGS)-1:0] RegNum;

   localparam RegNum R0 = '0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRead = 2'd1,
      StOut  = 2'd2
   } state_e;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if: request, operand, write-back and register-file port
// control signals of reg_access_ctrl. The shared data buses are not part of
// this bundle; they are plain inout ports on the controller.
//   request   : i_req_valid/o_req_ready, i_req_src0/1, i_req_dst
//   operands  : o_op_valid/i_op_ready, o_op_a, o_op_b, o_op_dst
//   writeback : i_wb_valid/o_wb_ready, i_wb_dst, i_wb_data
//   reg file  : o_reg_sel0/1, o_reg_read0/1, o_reg_write0/1
// Modports: slave (controller side), master (requester / register file side).
interface reg_access_ctrl_if
   import reg_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
);

   logic              i_req_valid;
   logic              o_req_ready;
   RegNum             i_req_src0;
   RegNum             i_req_src1;
   RegNum             i_req_dst;

   logic              o_op_valid;
   logic              i_op_ready;
   logic [DATA_W-1:0] o_op_a;
   logic [DATA_W-1:0] o_op_b;
   RegNum             o_op_dst;

   logic              i_wb_valid;
   logic              o_wb_ready;
   RegNum             i_wb_dst;
   logic [DATA_W-1:0] i_wb_data;

   RegNum             o_reg_sel0;
   RegNum             o_reg_sel1;
   logic              o_reg_read0;
   logic              o_reg_read1;
   logic              o_reg_write0;
   logic              o_reg_write1;

   modport slave (
      input  i_req_valid, i_req_src0, i_req_src1, i_req_dst,
      output o_req_ready,
      output o_op_valid, o_op_a, o_op_b, o_op_dst,
      input  i_op_ready,
      input  i_wb_valid, i_wb_dst, i_wb_data,
      output o_wb_ready,
      output o_reg_sel0, o_reg_sel1, o_reg_read0, o_reg_read1, o_reg_write0, o_reg_write1
   );

   modport master (
      output i_req_valid, i_req_src0, i_req_src1, i_req_dst,
      input  o_req_ready,
      input  o_op_valid, o_op_a, o_op_b, o_op_dst,
      output i_op_ready,
      output i_wb_valid, i_wb_dst, i_wb_data,
      input  o_wb_ready,
      input  o_reg_sel0, o_reg_sel1, o_reg_read0, o_reg_read1, o_reg_write0, o_reg_write1
   );

endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one busy bit per register. A destination is marked busy
// when its request is accepted and released when its write-back is accepted.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   set_en, set_idx    : mark register busy (request accept)
//   clr_en, clr_idx    : release register (write-back accept)
//   chk_src0/1, chk_dst: registers of the pending request
//   hazard             : any checked register is busy (registered state only)
module reg_scoreboard
   import reg_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  set_en,
   input  RegNum set_idx,
   input  logic  clr_en,
   input  RegNum clr_idx,
   input  RegNum chk_src0,
   input  RegNum chk_src1,
   input  RegNum chk_dst,
   output logic  hazard
);

   logic [NUM_REGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      // Set is applied after clear so it wins on a same-cycle collision.
      if (set_en) busy_d[set_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

   // Only registered bits are checked: a release unblocks one cycle later.
   assign hazard = busy_q[chk_src0] | busy_q[chk_src1] | busy_q[chk_dst];

endmodule

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: fetches two operands from a two-port register file for a
// request, delivers them with the destination, and forwards write-backs to
// register-file port 0.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   bus              : reg_access_ctrl_if.slave (handshakes, selects, strobes)
//   io_reg_data0/1   : shared register-file data buses (port 1 is read-only)
// Build option: define REG_ACCESS_SCOREBOARD_EN to stall requests on busy
// registers via reg_scoreboard; without it requests are accepted whenever idle.
module reg_access_ctrl
   import reg_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   reg_access_ctrl_if.slave        bus,
   inout  wire        [DATA_W-1:0] io_reg_data0,
   inout  wire        [DATA_W-1:0] io_reg_data1
);

   state_e            state_q, state_d;
   RegNum             src0_q, src1_q, dst_q;
   logic [DATA_W-1:0] op_a_q, op_b_q;

   logic  hazard;
   logic  req_ready, wb_ready;
   logic  req_accept, wb_accept;
   RegNum sel0, sel1;
   logic  read0, read1, write0;

   assign req_accept = bus.i_req_valid & req_ready;
   assign wb_accept  = bus.i_wb_valid & wb_ready;

`ifdef REG_ACCESS_SCOREBOARD_EN
   reg_scoreboard u_scoreboard (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .set_en   (req_accept),
      .set_idx  (bus.i_req_dst),
      .clr_en   (wb_accept),
      .clr_idx  (bus.i_wb_dst),
      .chk_src0 (bus.i_req_src0),
      .chk_src1 (bus.i_req_src1),
      .chk_dst  (bus.i_req_dst),
      .hazard   (hazard)
   );
`else
   assign hazard = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      wb_ready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = ~hazard;
            // Write-backs are refused while in reset so no write is issued.
            wb_ready  = i_rst_n;
            if (bus.i_req_valid && !hazard) state_d = StRead;
         end
         StRead: begin
            state_d = StOut;
         end
         StOut: begin
            wb_ready = i_rst_n;
            if (bus.i_op_ready) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Port 0 is shared: operand read in READ, otherwise write-back.
   always_comb begin
      sel0   = R0;
      sel1   = R0;
      read0  = 1'b0;
      read1  = 1'b0;
      write0 = 1'b0;
      if (state_q == StRead) begin
         sel0  = src0_q;
         read0 = 1'b1;
         sel1  = src1_q;
         read1 = 1'b1;
      end else if (wb_accept) begin
         sel0   = bus.i_wb_dst;
         write0 = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         src0_q  <= R0;
         src1_q  <= R0;
         dst_q   <= R0;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         if (req_accept) begin
            src0_q <= bus.i_req_src0;
            src1_q <= bus.i_req_src1;
            dst_q  <= bus.i_req_dst;
         end
         if (state_q == StRead) begin
            op_a_q <= io_reg_data0;
            op_b_q <= io_reg_data1;
         end
      end
   end

   assign bus.o_req_ready  = req_ready;
   assign bus.o_wb_ready   = wb_ready;
   assign bus.o_op_valid   = (state_q == StOut);
   assign bus.o_op_a       = op_a_q;
   assign bus.o_op_b       = op_b_q;
   assign bus.o_op_dst     = dst_q;
   assign bus.o_reg_sel0   = sel0;
   assign bus.o_reg_sel1   = sel1;
   assign bus.o_reg_read0  = read0;
   assign bus.o_reg_read1  = read1;
   assign bus.o_reg_write0 = write0;
   assign bus.o_reg_write1 = 1'b0;

   assign io_reg_data0 = write0 ? bus.i_wb_data : 'z;
   assign io_reg_data1 = 'z;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: drives reg_access_ctrl with a behavioural two-port
// register file on the data buses. Expected operands are computed from a
// bench-side register model when a request is accepted, queued, and checked
// when the operands are handed over.
module tb_reg_access_ctrl;
   import reg_pkg::*;

   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      RegNum         dst;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   wire [DW-1:0] reg_data0;
   wire [DW-1:0] reg_data1;

   logic [DW-1:0] rf       [NUM_REGS] = '{default: '0};
   logic [DW-1:0] model_rf [NUM_REGS] = '{default: '0};
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   reg_access_ctrl_if #(.DATA_W(DW)) bus ();

   reg_access_ctrl #(.DATA_W(DW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .bus          (bus),
      .io_reg_data0 (reg_data0),
      .io_reg_data1 (reg_data1)
   );

   always #5 clk = ~clk;

   // Register file: asynchronous read on strobe, write captured at the edge.
   assign reg_data0 = bus.o_reg_read0 ? rf[bus.o_reg_sel0] : 'z;
   assign reg_data1 = bus.o_reg_read1 ? rf[bus.o_reg_sel1] : 'z;
   always @(posedge clk) if (bus.o_reg_write0) rf[bus.o_reg_sel0] <= reg_data0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // Stimulus helpers: all are entered and left just after a rising edge.
   task automatic send_req(input RegNum s0, input RegNum s1, input RegNum d, output bit ok);
      exp_t e;
      ok = 1'b0;
      bus.i_req_src0 = s0; bus.i_req_src1 = s1; bus.i_req_dst = d; bus.i_req_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.o_req_ready) begin
            e.a = model_rf[s0]; e.b = model_rf[s1]; e.dst = d;
            exp_q.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.i_req_valid = 1'b0;
   endtask

   task automatic send_wb(input RegNum d, input logic [DW-1:0] data, output bit ok);
      ok = 1'b0;
      bus.i_wb_dst = d; bus.i_wb_data = data; bus.i_wb_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = bus.o_wb_ready;
         @(posedge clk); #1;
      end
      if (ok) model_rf[d] = data;
      bus.i_wb_valid = 1'b0;
   endtask

   task automatic collect_op(output exp_t got, output bit ok);
      ok = 1'b0;
      got = '0;
      bus.i_op_ready = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.o_op_valid) begin
            got.a = bus.o_op_a; got.b = bus.o_op_b; got.dst = bus.o_op_dst;
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.i_op_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_req_valid = 1'b0; bus.i_op_ready = 1'b0; bus.i_wb_valid = 1'b0;
      bus.i_req_src0 = R0; bus.i_req_src1 = R0; bus.i_req_dst = R0;
      bus.i_wb_dst = R0; bus.i_wb_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.o_op_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_op_valid: got %b want 0", bus.o_op_valid);
      end
      n_cmp++;
      if (bus.o_op_a !== '0 || bus.o_op_b !== '0 || bus.o_op_dst !== R0) begin
         n_bad++;
         $display("FAIL reset_operands: got a=%h b=%h dst=%0d want 0 0 0",
                  bus.o_op_a, bus.o_op_b, bus.o_op_dst);
      end
      n_cmp++;
      if ({bus.o_reg_read0, bus.o_reg_read1, bus.o_reg_write0, bus.o_reg_write1} !== 4'b0000
          || bus.o_reg_sel0 !== R0 || bus.o_reg_sel1 !== R0) begin
         n_bad++; $display("FAIL reset_strobes: strobes or selects active, want all 0");
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_req_ready !== 1'b1 || bus.o_wb_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_ready: got req=%b wb=%b want 1 1", bus.o_req_ready, bus.o_wb_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_preload();
      bit ok;
      bus.i_wb_dst = RegNum'(3); bus.i_wb_data = 32'h11; bus.i_wb_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_wb_ready !== 1'b1 || bus.o_reg_write0 !== 1'b1 || bus.o_reg_sel0 !== 5'd3
          || bus.o_reg_read0 !== 1'b0 || bus.o_reg_write1 !== 1'b0 || reg_data0 !== 32'h11) begin
         n_bad++;
         $display("FAIL wb_port0: got rdy=%b wr0=%b sel0=%0d rd0=%b wr1=%b data=%h want 1 1 3 0 0 11",
                  bus.o_wb_ready, bus.o_reg_write0, bus.o_reg_sel0, bus.o_reg_read0,
                  bus.o_reg_write1, reg_data0);
      end
      @(posedge clk); #1;
      bus.i_wb_valid = 1'b0;
      model_rf[3] = 32'h11;
      @(negedge clk);
      n_cmp++;
      if (bus.o_reg_write0 !== 1'b0 || rf[3] !== 32'h11) begin
         n_bad++; $display("FAIL wb_r3: got wr0=%b R3=%h want 0 11", bus.o_reg_write0, rf[3]);
      end
      @(posedge clk); #1;
      send_wb(RegNum'(7), 32'h22, ok);
      n_cmp++;
      if (!ok || rf[7] !== 32'h22) begin
         n_bad++; $display("FAIL wb_r7: got ok=%b R7=%h want 1 22", ok, rf[7]);
      end
   endtask

   task automatic test_basic();
      bit   ok;
      exp_t got, exp;
      bus.i_req_src0 = RegNum'(3); bus.i_req_src1 = RegNum'(7); bus.i_req_dst = RegNum'(9);
      bus.i_req_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_req_ready !== 1'b1) begin
         n_bad++; $display("FAIL basic_ready: got %b want 1", bus.o_req_ready);
      end
      exp.a = model_rf[3]; exp.b = model_rf[7]; exp.dst = RegNum'(9);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.o_reg_read0 !== 1'b1 || bus.o_reg_sel0 !== 5'd3 || bus.o_reg_read1 !== 1'b1
          || bus.o_reg_sel1 !== 5'd7 || bus.o_reg_write0 !== 1'b0 || bus.o_req_ready !== 1'b0
          || bus.o_wb_ready !== 1'b0 || bus.o_op_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL read_cycle: got rd0=%b sel0=%0d rd1=%b sel1=%0d wr0=%b rq=%b wb=%b v=%b want 1 3 1 7 0 0 0 0",
                  bus.o_reg_read0, bus.o_reg_sel0, bus.o_reg_read1, bus.o_reg_sel1,
                  bus.o_reg_write0, bus.o_req_ready, bus.o_wb_ready, bus.o_op_valid);
      end
      @(posedge clk); #1;
      // Held operands must stay valid and stable while the consumer stalls.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.o_op_valid !== 1'b1 || bus.o_op_a !== 32'h11 || bus.o_op_b !== 32'h22
             || bus.o_op_dst !== 5'd9 || bus.o_req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_%0d: got v=%b a=%h b=%h dst=%0d rq=%b want 1 11 22 9 0",
                     i, bus.o_op_valid, bus.o_op_a, bus.o_op_b, bus.o_op_dst, bus.o_req_ready);
         end
         @(posedge clk); #1;
      end
      collect_op(got, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
         n_bad++; $display("FAIL basic_op: got no delivery want a=11 b=22 dst=9");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_bad++;
            $display("FAIL basic_op: got a=%h b=%h dst=%0d want a=%h b=%h dst=%0d",
                     got.a, got.b, got.dst, exp.a, exp.b, exp.dst);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.o_op_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_done: got v=%b rq=%b want 0 1", bus.o_op_valid, bus.o_req_ready);
      end
      @(posedge clk); #1;
      send_wb(RegNum'(9), 32'h99, ok);
   endtask

   task automatic test_wb_during_read();
      bit   ok;
      exp_t got, exp;
      send_req(RegNum'(3), RegNum'(7), RegNum'(10), ok);
      bus.i_wb_dst = RegNum'(5); bus.i_wb_data = 32'hDEAD; bus.i_wb_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (!ok || bus.o_wb_ready !== 1'b0 || bus.o_reg_write0 !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_in_read: got ok=%b wb=%b wr0=%b want 1 0 0",
                  ok, bus.o_wb_ready, bus.o_reg_write0);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rf[5] !== '0) begin
         n_bad++; $display("FAIL wb_in_read_nowrite: got R5=%h want 0", rf[5]);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.o_wb_ready !== 1'b1 || bus.o_reg_write0 !== 1'b1 || bus.o_reg_sel0 !== 5'd5
          || reg_data0 !== 32'hDEAD) begin
         n_bad++;
         $display("FAIL wb_in_out: got wb=%b wr0=%b sel0=%0d data=%h want 1 1 5 dead",
                  bus.o_wb_ready, bus.o_reg_write0, bus.o_reg_sel0, reg_data0);
      end
      @(posedge clk); #1;
      bus.i_wb_valid = 1'b0;
      model_rf[5] = 32'hDEAD;
      n_cmp++;
      if (rf[5] !== 32'hDEAD) begin
         n_bad++; $display("FAIL wb_r5: got R5=%h want dead", rf[5]);
      end
      collect_op(got, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
         n_bad++; $display("FAIL wbread_op: got no delivery want dst=10");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_bad++;
            $display("FAIL wbread_op: got a=%h b=%h dst=%0d want a=%h b=%h dst=%0d",
                     got.a, got.b, got.dst, exp.a, exp.b, exp.dst);
         end
      end
      send_wb(RegNum'(10), 32'hAA, ok);
   endtask

   task automatic test_hazard();
      bit   ok;
      exp_t got, exp;
      send_req(RegNum'(1), RegNum'(2), RegNum'(4), ok);
      collect_op(got, ok);
      void'(exp_q.pop_front());
      bus.i_req_src0 = RegNum'(4); bus.i_req_src1 = RegNum'(2); bus.i_req_dst = RegNum'(6);
      bus.i_req_valid = 1'b1;
`ifdef REG_ACCESS_SCOREBOARD_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.o_req_ready !== 1'b0) begin
            n_bad++; $display("FAIL hazard_stall_%0d: got rq=%b want 0", i, bus.o_req_ready);
         end
         @(posedge clk); #1;
      end
      bus.i_wb_dst = RegNum'(4); bus.i_wb_data = 32'h5; bus.i_wb_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_wb_ready !== 1'b1 || bus.o_req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL hazard_wb_cycle: got wb=%b rq=%b want 1 0",
                  bus.o_wb_ready, bus.o_req_ready);
      end
      @(posedge clk); #1;
      bus.i_wb_valid = 1'b0;
      model_rf[4] = 32'h5;
`endif
      @(negedge clk);
      n_cmp++;
      if (bus.o_req_ready !== 1'b1) begin
         n_bad++; $display("FAIL hazard_release: got rq=%b want 1", bus.o_req_ready);
      end
      exp.a = model_rf[4]; exp.b = model_rf[2]; exp.dst = RegNum'(6);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      collect_op(got, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
         n_bad++; $display("FAIL hazard_op: got no delivery want dst=6");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_bad++;
            $display("FAIL hazard_op: got a=%h b=%h dst=%0d want a=%h b=%h dst=%0d",
                     got.a, got.b, got.dst, exp.a, exp.b, exp.dst);
         end
      end
      send_wb(RegNum'(4), 32'h5, ok);
      send_wb(RegNum'(6), 32'h66, ok);
   endtask

   task automatic test_set_wins();
      bit   ok;
      exp_t got, exp;
      bus.i_req_src0 = RegNum'(3); bus.i_req_src1 = RegNum'(7); bus.i_req_dst = RegNum'(12);
      bus.i_req_valid = 1'b1;
      bus.i_wb_dst = RegNum'(12); bus.i_wb_data = 32'h77; bus.i_wb_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_req_ready !== 1'b1 || bus.o_wb_ready !== 1'b1 || bus.o_reg_write0 !== 1'b1
          || bus.o_reg_sel0 !== 5'd12) begin
         n_bad++;
         $display("FAIL same_cycle: got rq=%b wb=%b wr0=%b sel0=%0d want 1 1 1 12",
                  bus.o_req_ready, bus.o_wb_ready, bus.o_reg_write0, bus.o_reg_sel0);
      end
      model_rf[12] = 32'h77;
      exp.a = model_rf[3]; exp.b = model_rf[7]; exp.dst = RegNum'(12);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0; bus.i_wb_valid = 1'b0;
      n_cmp++;
      if (rf[12] !== 32'h77) begin
         n_bad++; $display("FAIL wb_r12: got R12=%h want 77", rf[12]);
      end
      collect_op(got, ok);
      void'(exp_q.pop_front());
      bus.i_req_src0 = RegNum'(12); bus.i_req_src1 = R0; bus.i_req_dst = RegNum'(15);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
`ifdef REG_ACCESS_SCOREBOARD_EN
         if (bus.o_req_ready !== 1'b0) begin
            n_bad++; $display("FAIL set_wins_%0d: got rq=%b want 0", i, bus.o_req_ready);
         end
`else
         if (bus.o_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL no_sb_ready_%0d: got rq=%b want 1", i, bus.o_req_ready);
         end
`endif
         @(posedge clk); #1;
      end
      send_wb(RegNum'(12), 32'h78, ok);
      send_req(RegNum'(12), R0, RegNum'(15), ok);
      collect_op(got, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
         n_bad++; $display("FAIL r12_op: got no delivery want a=78 dst=15");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_bad++;
            $display("FAIL r12_op: got a=%h b=%h dst=%0d want a=%h b=%h dst=%0d",
                     got.a, got.b, got.dst, exp.a, exp.b, exp.dst);
         end
      end
      send_wb(RegNum'(15), 32'h15, ok);
   endtask

   task automatic test_reset_mid();
      bit   ok;
      exp_t got, exp;
      send_req(RegNum'(3), RegNum'(7), RegNum'(13), ok);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_op_valid !== 1'b1) begin
         n_bad++; $display("FAIL pre_reset_valid: got %b want 1", bus.o_op_valid);
      end
      #1;
      rst_n = 1'b0;
      bus.i_wb_dst = RegNum'(14); bus.i_wb_data = 32'hBAD; bus.i_wb_valid = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_op_valid !== 1'b0 || bus.o_op_a !== '0 || bus.o_op_dst !== R0
          || bus.o_reg_write0 !== 1'b0 || bus.o_reg_read0 !== 1'b0 || bus.o_wb_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: got v=%b a=%h dst=%0d wr0=%b rd0=%b wb=%b want 0 0 0 0 0 0",
                  bus.o_op_valid, bus.o_op_a, bus.o_op_dst, bus.o_reg_write0,
                  bus.o_reg_read0, bus.o_wb_ready);
      end
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1;
      n_cmp++;
      if (rf[14] !== '0) begin
         n_bad++; $display("FAIL reset_nowrite: got R14=%h want 0", rf[14]);
      end
      bus.i_wb_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_req_src0 = RegNum'(13); bus.i_req_src1 = R0; bus.i_req_dst = RegNum'(13);
      #1;
      n_cmp++;
      if (bus.o_req_ready !== 1'b1) begin
         n_bad++; $display("FAIL busy_cleared: got rq=%b want 1", bus.o_req_ready);
      end
      @(posedge clk); #1;
      send_req(RegNum'(13), R0, RegNum'(13), ok);
      collect_op(got, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
         n_bad++; $display("FAIL post_reset_op: got no delivery want dst=13");
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_bad++;
            $display("FAIL post_reset_op: got a=%h b=%h dst=%0d want a=%h b=%h dst=%0d",
                     got.a, got.b, got.dst, exp.a, exp.b, exp.dst);
         end
      end
      send_wb(RegNum'(13), 32'h13, ok);
   endtask

   initial begin
      test_reset();
      test_preload();
      test_basic();
      test_wb_during_read();
      test_hazard();
      test_set_wins();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
